// File: rtl/layer_fetch_sequencer.sv
// Address and read sequencer for one dense-layer pass.
// It streams x and per-lane weight words out of a memory with a 1-cycle
// registered read, then reads the biases. Valid, first and last strobes are
// delayed one cycle so they line up with the read data at the MAC array.
//
// state   | meaning
// S_IDLE  | waiting for start, all outputs 0
// S_INIT  | one cycle per lane, builds row_base[k] = w_base + k*in_len
// S_FETCH | one x/w element per mac_ready cycle
// S_BIAS  | one unconditional read of all lane biases
// S_DRAIN | bias data on the memory outputs (bias_valid)
// S_DONE  | one-cycle done pulse
module layer_fetch_sequencer #(
  parameter int N_NEURONS = 10,
  parameter int ADDR_W    = 16
) (
  input  logic                          clock_mem,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mac_ready,
  input  logic [ADDR_W-1:0]             x_base,
  input  logic [ADDR_W-1:0]             w_base,
  input  logic [ADDR_W-1:0]             b_base,
  input  logic [ADDR_W-1:0]             in_len,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             x_addr,
  output logic [N_NEURONS*ADDR_W-1:0]   w_addr,
  output logic [N_NEURONS*ADDR_W-1:0]   b_addr,
  output logic                          data_valid,
  output logic                          data_first,
  output logic                          data_last,
  output logic                          bias_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_BIAS, S_DRAIN, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_x;
  logic [ADDR_W-1:0]  r_b;
  logic [ADDR_W-1:0]  r_len;
  logic [ADDR_W-1:0]  r_acc;
  logic [ADDR_W-1:0]  r_idx;
  logic [RW-1:0]      r_row;
  logic [ADDR_W-1:0]  r_row_base [N_NEURONS];
  logic               r_dv;
  logic               r_df;
  logic               r_dl;
  logic               w_fetch_rd;
  logic               w_last_idx;

  assign w_fetch_rd = (r_state == S_FETCH) && mac_ready;
  assign w_last_idx = (r_idx == r_len - ADDR_W'(1));

  assign data_valid = r_dv;
  assign data_first = r_df;
  assign data_last  = r_dl;

  // State register
  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and combinational outputs (addresses are 0 outside their phase)
  always_comb begin
    w_next     = r_state;
    rd_en      = 1'b0;
    x_addr     = '0;
    w_addr     = '0;
    b_addr     = '0;
    bias_valid = 1'b0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        if (r_row == LAST_ROW) w_next = (r_len == '0) ? S_BIAS : S_FETCH;
      end
      S_FETCH: begin
        rd_en  = mac_ready;
        x_addr = r_x + r_idx;
        for (int k = 0; k < N_NEURONS; k++)
          w_addr[k*ADDR_W +: ADDR_W] = r_row_base[k] + r_idx;
        if (mac_ready && w_last_idx) w_next = S_BIAS;
      end
      S_BIAS: begin
        rd_en = 1'b1;
        for (int k = 0; k < N_NEURONS; k++)
          b_addr[k*ADDR_W +: ADDR_W] = r_b + ADDR_W'(k);
        w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bias_valid = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Captured operands, row-base accumulator, element index and delayed strobes
  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_b   <= '0;
      r_len <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_row <= '0;
      r_dv  <= 1'b0;
      r_df  <= 1'b0;
      r_dl  <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) r_row_base[k] <= '0;
    end else begin
      r_dv <= w_fetch_rd;
      r_df <= w_fetch_rd && (r_idx == '0);
      r_dl <= w_fetch_rd && w_last_idx;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= x_base;
            r_b   <= b_base;
            r_len <= in_len;
            r_acc <= w_base;
            r_idx <= '0;
            r_row <= '0;
          end
        end
        S_INIT: begin
          r_row_base[r_row] <= r_acc;
          r_acc             <= r_acc + r_len;
          r_row             <= r_row + RW'(1);
        end
        S_FETCH: begin
          if (w_fetch_rd) r_idx <= r_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/layer_fetch_sequencer.md
Name: layer_fetch_sequencer

Overview:
- Address/read sequencer directly upstream of main_memory_32k_x_32bit.
- Drives rd_en plus the x, 10 weight and 10 bias address pointers, so one dense-layer pass (10 neurons × in_len inputs) streams out of memory.
- Emits aligned valid/first/last/bias strobes, compensating for the memory's 1-cycle registered read latency, to the downstream 10-lane MAC array.
- Supports back-pressure from the MAC array via mac_ready.

Parameters:
- N_NEURONS, 10, number of parallel neuron lanes (weight/bias pointer count).
- ADDR_W, 16, address width of every pointer.

Ports:
- clock_mem  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- mac_ready  in  1  downstream can accept a new input element this cycle.
- x_base  in  ADDR_W  address of input element 0; captured on start.
- w_base  in  ADDR_W  address of neuron 0 weight 0 (row-major, row length in_len); captured on start.
- b_base  in  ADDR_W  address of neuron 0 bias (contiguous, one word per neuron); captured on start.
- in_len  in  ADDR_W  inputs per neuron; captured on start.
- rd_en  out  1  memory read enable.
- x_addr  out  ADDR_W  input pointer.
- w_addr  out  N_NEURONS*ADDR_W  packed weight pointers, lane k at bits [k*ADDR_W +: ADDR_W].
- b_addr  out  N_NEURONS*ADDR_W  packed bias pointers, same packing.
- data_valid  out  1  memory x/w outputs hold a fresh element this cycle.
- data_first  out  1  qualifies data_valid: element index 0.
- data_last  out  1  qualifies data_valid: element index in_len-1.
- bias_valid  out  1  memory b outputs hold this layer's biases this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (async):
  - state=IDLE; index, row counter and captured registers cleared.
  - All outputs 0, including every address.
  - Reset mid-pass abandons the pass; no done pulse.
- IDLE:
  - Outputs 0.
  - start=1 captures x_base, w_base, b_base and in_len, clears the row counter, and moves to INIT.
  - start while not IDLE is ignored.
- INIT (exactly N_NEURONS cycles, no reads):
  - Cycle k computes row_base[k] = w_base + k*in_len using one running accumulator (acc += in_len).
  - After lane N_NEURONS-1, go to FETCH, or straight to BIAS if in_len==0.
- FETCH:
  - rd_en = mac_ready (combinational).
  - Addresses are combinational from registers: x_addr = x_base_q + idx; w_addr lane k = row_base[k] + idx.
  - On an edge with rd_en=1, idx increments.
  - When idx==in_len-1 is read, go to BIAS.
  - mac_ready=0: rd_en=0, idx and addresses hold.
- BIAS (1 cycle):
  - rd_en=1 unconditionally.
  - b_addr lane k = b_base_q + k; x_addr and w_addr = 0.
  - Next state is DRAIN.
- DRAIN (1 cycle): bias_valid=1; then DONE.
- DONE (1 cycle): done=1; then IDLE. start in this cycle is ignored.
- Latency: data_valid/first/last are rd_en/first/last registered one cycle, because memory data appears the cycle after the read edge. They are 0 when the previous cycle had no FETCH read.
- Arithmetic: all address sums are modulo 2^ADDR_W (wrap, no error).
- in_len==1: data_first and data_last assert together.
- Memory wr_en is not driven by this block; it must be held 0 externally during busy.
- Timing with no stalls: start sampled at edge 0 gives
  - INIT cycles 1..10
  - FETCH cycles 11..10+in_len
  - BIAS 11+in_len
  - bias_valid 12+in_len
  - done 13+in_len

Test Plan:
- Basic pass:
  - Stimulus: x_base=0x0000, w_base=0x0100, b_base=0x0200, in_len=4, mac_ready=1.
  - Response: rd_en cycles 11–14 with x_addr 0..3 and lane 3 w_addr 0x010C..0x010F; lane 9 w_addr starts at 0x0124.
  - Then cycle 15 b_addr lanes 0x0200..0x0209, bias_valid at 16, done at 17.
  - data_first at 12, data_last at 15.
- Stall:
  - Stimulus: same setup, mac_ready=0 during cycles 12–13.
  - Response: rd_en low those cycles, x_addr holds 1, data_valid low at 13–14, last read at cycle 16, done at 19.
- Edge lengths:
  - Stimulus: in_len=0, then in_len=1.
  - Response: in_len=0 has no FETCH reads, no data_valid, done at cycle 13.
  - in_len=1 has a single read with data_first=data_last=1.
- Wrap:
  - Stimulus: w_base=0xFFFE, in_len=2.
  - Response: lane 1 reads 0x0000,0x0001; lane 9 reads 0x0010,0x0011.
- Reset mid-pass and start ignored while busy:
  - Stimulus: assert start at cycle 12 of a pass, then rst asynchronously at cycle 13.
  - Response: start has no effect; on rst all outputs go 0 immediately, busy=0, no done; a fresh start afterwards behaves as in the basic pass.
